// File: rtl/pcie_phy_pkg.sv
// -----------------------------------------------------------------------------
// pcie_phy_pkg
//   Types and constants shared across the PCIe PHY transmit path.
//   - SYMBOL_WIDTH_8B10B : width of an 8b/10b encoded symbol
//   - symbol10_t         : one encoded symbol, "a" at bit 9
//   - ser_state_t        : serializer FSM states
//   - K28_5_RDN/RDP      : comma symbols for benches and idle generators
// -----------------------------------------------------------------------------
package pcie_phy_pkg;

    localparam int SYMBOL_WIDTH_8B10B = 10;

    typedef logic [9:0] symbol10_t;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    localparam symbol10_t K28_5_RDN = 10'b0011111010;
    localparam symbol10_t K28_5_RDP = 10'b1100000101;

endpackage

// File: rtl/tx_serializer_10b.sv
// -----------------------------------------------------------------------------
// tx_serializer_10b
//   Parallel-to-serial stage behind the 8b/10b encoder. Accepts encoded
//   symbols over valid/ready, keeps one symbol in a holding register behind
//   the one being shifted, and emits one line bit per clock with no gap
//   between back-to-back symbols. Flags an underrun when the line goes idle
//   because no follow-on symbol is available.
//
// Handshake: symbol_in is transferred on a rising edge where
//   symbol_valid && symbol_ready. symbol_ready is !hold_full, a registered
//   value with no combinational path from symbol_valid; upstream must keep
//   symbol_in stable while valid is high and ready is low.
//
// Ports:
//   clk           in   line clock, one serial bit per cycle
//   reset         in   synchronous, active-high
//   symbol_in     in   [SYMBOL_WIDTH] encoded symbol
//   symbol_valid  in   symbol_in valid
//   symbol_ready  out  holding buffer empty
//   tx_en         in   allow a new symbol to start shifting
//   serial_out    out  line bit
//   serial_valid  out  serial_out carries a symbol bit
//   symbol_start  out  serial_out carries the first bit of a symbol
//   underrun      out  one-cycle pulse on the first idle cycle after starvation
// -----------------------------------------------------------------------------
module tx_serializer_10b
    import pcie_phy_pkg::*;
#(
    parameter int SYMBOL_WIDTH = SYMBOL_WIDTH_8B10B,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SYMBOL_WIDTH-1:0] symbol_in,
    input  logic                    symbol_valid,
    output logic                    symbol_ready,
    input  logic                    tx_en,
    output logic                    serial_out,
    output logic                    serial_valid,
    output logic                    symbol_start,
    output logic                    underrun
);

    localparam int CNT_W = (SYMBOL_WIDTH > 2) ? $clog2(SYMBOL_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SYMBOL_WIDTH - 1);

    // Bit that goes on the line first from a freshly loaded symbol.
    function automatic logic first_bit(input logic [SYMBOL_WIDTH-1:0] sym);
        return MSB_FIRST ? sym[SYMBOL_WIDTH-1] : sym[0];
    endfunction

    // Moves the next line bit into the position first_bit() reads.
    function automatic logic [SYMBOL_WIDTH-1:0] shift_one(input logic [SYMBOL_WIDTH-1:0] sym);
        return MSB_FIRST ? {sym[SYMBOL_WIDTH-2:0], 1'b0} : {1'b0, sym[SYMBOL_WIDTH-1:1]};
    endfunction

    ser_state_t              state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [SYMBOL_WIDTH-1:0] shift_q, shift_d;
    logic [SYMBOL_WIDTH-1:0] hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic                    serial_out_q, serial_out_d;
    logic                    serial_valid_q, serial_valid_d;
    logic                    symbol_start_q, symbol_start_d;
    logic                    underrun_q, underrun_d;

    logic                    accept;
    logic                    at_boundary;
    logic                    load_hold;
    logic                    load_bypass;
    logic                    load;
    logic [SYMBOL_WIDTH-1:0] load_src;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= SER_IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            symbol_start_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            symbol_start_q <= symbol_start_d;
            underrun_q     <= underrun_d;
        end
    end

    always_comb begin
        accept      = symbol_valid && !hold_full_q;
        // The shifter can take a new symbol when idle, or on the edge that
        // retires the last bit of the current one (gap-free hand-over).
        at_boundary = (state_q == SER_IDLE) || (bit_cnt_q == LAST_BIT);
        load_hold   = at_boundary && tx_en && hold_full_q;
        load_bypass = at_boundary && tx_en && !hold_full_q && accept;
        load        = load_hold || load_bypass;
        load_src    = hold_full_q ? hold_q : symbol_in;

        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        serial_out_d   = 1'b0;
        serial_valid_d = 1'b0;
        symbol_start_d = 1'b0;
        underrun_d     = 1'b0;

        if ((state_q == SER_SHIFT) && (bit_cnt_q != LAST_BIT)) begin
            bit_cnt_d      = bit_cnt_q + 1'b1;
            serial_out_d   = first_bit(shift_q);
            shift_d        = shift_one(shift_q);
            serial_valid_d = 1'b1;
        end else if (load) begin
            state_d        = SER_SHIFT;
            bit_cnt_d      = '0;
            serial_out_d   = first_bit(load_src);
            shift_d        = shift_one(load_src);
            serial_valid_d = 1'b1;
            symbol_start_d = 1'b1;
        end else begin
            state_d   = SER_IDLE;
            bit_cnt_d = '0;
            // Starvation only: a symbol parked in hold (or arriving into it
            // this edge) while tx_en is low is a deliberate pause.
            underrun_d = (state_q == SER_SHIFT) && !hold_full_q && !accept;
        end

        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (load_hold) begin
            hold_full_d = 1'b0;
        end else if (accept && !load_bypass) begin
            hold_d      = symbol_in;
            hold_full_d = 1'b1;
        end
    end

    assign symbol_ready = !hold_full_q;
    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign symbol_start = symbol_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_tx_serializer_10b.sv
// -----------------------------------------------------------------------------
// tb_tx_serializer_10b
//   Bench for tx_serializer_10b. The main instance (MSB first) is tracked by a
//   queue-based line model; a second instance built LSB first is checked
//   against the documented bit pattern for D0.0.
// -----------------------------------------------------------------------------
module tb_tx_serializer_10b;
    import pcie_phy_pkg::*;

    localparam int SW = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic [SW-1:0] symbol_in = '0;
    logic          symbol_valid = 1'b0;
    logic          tx_en = 1'b1;
    logic          symbol_ready, serial_out, serial_valid, symbol_start, underrun;

    logic [SW-1:0] l_symbol_in = '0;
    logic          l_symbol_valid = 1'b0;
    logic          l_tx_en = 1'b1;
    logic          l_symbol_ready, l_serial_out, l_serial_valid, l_symbol_start, l_underrun;

    tx_serializer_10b #(.SYMBOL_WIDTH(SW), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset),
        .symbol_in(symbol_in), .symbol_valid(symbol_valid), .symbol_ready(symbol_ready),
        .tx_en(tx_en),
        .serial_out(serial_out), .serial_valid(serial_valid),
        .symbol_start(symbol_start), .underrun(underrun)
    );

    tx_serializer_10b #(.SYMBOL_WIDTH(SW), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset),
        .symbol_in(l_symbol_in), .symbol_valid(l_symbol_valid), .symbol_ready(l_symbol_ready),
        .tx_en(l_tx_en),
        .serial_out(l_serial_out), .serial_valid(l_serial_valid),
        .symbol_start(l_symbol_start), .underrun(l_underrun)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // ---------------- reference model ----------------
    // m_line holds the bits still to appear on the line, front = bit on the
    // line now. m_hold is the one-deep buffer behind it.
    logic          m_line[$];
    logic [SW-1:0] m_hold[$];
    logic          m_start = 1'b0;
    logic          m_under = 1'b0;
    logic          m_acc = 1'b0;
    logic [4:0]    m_exp = 5'b00001;   // {valid, out, start, underrun, ready}
    logic [4:0]    obs;

    task automatic model_step();
        logic          busy;
        logic          loaded;
        logic          used;
        logic [SW-1:0] sym;
        m_acc  = symbol_valid && (m_hold.size() == 0);
        loaded = 1'b0;
        used   = 1'b0;
        sym    = '0;
        if (reset) begin
            m_line.delete();
            m_hold.delete();
            m_start = 1'b0;
            m_under = 1'b0;
            m_acc   = 1'b0;
        end else begin
            busy = (m_line.size() > 0);
            if (busy) void'(m_line.pop_front());
            m_start = 1'b0;
            if ((m_line.size() == 0) && tx_en) begin
                if (m_hold.size() > 0) begin
                    sym    = m_hold.pop_front();
                    loaded = 1'b1;
                end else if (m_acc) begin
                    sym    = symbol_in;
                    loaded = 1'b1;
                    used   = 1'b1;
                end
                if (loaded) begin
                    for (int k = 0; k < SW; k++) m_line.push_back(sym[SW-1-k]);
                    m_start = 1'b1;
                end
            end
            if (m_acc && !used) m_hold.push_back(symbol_in);
            m_under = busy && (m_line.size() == 0) && (m_hold.size() == 0);
        end
        m_exp = {(m_line.size() > 0), (m_line.size() > 0) ? m_line[0] : 1'b0,
                 m_start, m_under, (m_hold.size() == 0)};
    endtask

    // ---------------- driver ----------------
    // Inputs are applied before the rising edge; outputs are sampled on the
    // following falling edge.
    task automatic clock_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        obs = {serial_valid, serial_out, symbol_start, underrun, symbol_ready};
    endtask

    task automatic idle_inputs();
        symbol_valid = 1'b0;
        tx_en        = 1'b1;
        reset        = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset        = 1'b1;
        symbol_valid = 1'b1;
        symbol_in    = 10'h2AA;
        l_symbol_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clock_cycle();
            checks++;
            if (obs !== 5'b00001)
                begin failures++; $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", cyc, obs, 5'b00001); end
            checks++;
            if ({l_serial_valid, l_serial_out, l_symbol_start, l_underrun, l_symbol_ready} !== 5'b00001)
                begin failures++; $display("FAIL reset_lsb_outputs cyc=%0d got=%b exp=%b", cyc,
                    {l_serial_valid, l_serial_out, l_symbol_start, l_underrun, l_symbol_ready}, 5'b00001); end
        end
        l_symbol_valid = 1'b0;
        idle_inputs();
        clock_cycle();
        checks++;
        if (obs !== m_exp)
            begin failures++; $display("FAIL post_reset_idle cyc=%0d got=%b exp=%b", cyc, obs, m_exp); end
    endtask

    task automatic test_single_bypass();
        logic [SW-1:0] got = '0;
        logic [SW-1:0] starts = '0;
        symbol_in    = 10'h274;
        symbol_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            clock_cycle();
            symbol_valid = 1'b0;
            checks++;
            if (obs !== m_exp)
                begin failures++; $display("FAIL bypass_model cyc=%0d got=%b exp=%b", cyc, obs, m_exp); end
            if (i < SW) begin
                got[SW-1-i]    = serial_out;
                starts[SW-1-i] = symbol_start;
                checks++;
                if (serial_valid !== 1'b1)
                    begin failures++; $display("FAIL bypass_valid bit=%0d got=%b exp=1", i, serial_valid); end
            end else begin
                checks++;
                if ({serial_valid, underrun} !== {1'b0, (i == SW)})
                    begin failures++; $display("FAIL bypass_underrun i=%0d got=%b exp=%b", i,
                        {serial_valid, underrun}, {1'b0, (i == SW)}); end
            end
        end
        checks++;
        if (got !== 10'b1001110100)
            begin failures++; $display("FAIL bypass_bits got=%b exp=%b", got, 10'b1001110100); end
        checks++;
        if (starts !== 10'b1000000000)
            begin failures++; $display("FAIL bypass_start got=%b exp=%b", starts, 10'b1000000000); end
    endtask

    task automatic test_back_to_back();
        logic [2*SW-1:0] got = '0;
        logic [2*SW-1:0] starts = '0;
        int nbits = 0;
        int stage = 0;
        logic early_under = 1'b0;
        symbol_in    = K28_5_RDN;
        symbol_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            clock_cycle();
            if (m_acc) begin
                stage++;
                if (stage == 1) symbol_in = K28_5_RDP;
                else symbol_valid = 1'b0;
            end
            checks++;
            if (obs !== m_exp)
                begin failures++; $display("FAIL b2b_model cyc=%0d got=%b exp=%b", cyc, obs, m_exp); end
            if (underrun && (nbits < 2*SW)) early_under = 1'b1;
            if (serial_valid && (nbits < 2*SW)) begin
                got[2*SW-1-nbits]    = serial_out;
                starts[2*SW-1-nbits] = symbol_start;
                nbits++;
            end
        end
        checks++;
        if (got !== {K28_5_RDN, K28_5_RDP})
            begin failures++; $display("FAIL b2b_bits got=%b exp=%b", got, {K28_5_RDN, K28_5_RDP}); end
        checks++;
        if (starts !== 20'b1000000000_1000000000)
            begin failures++; $display("FAIL b2b_start got=%b exp=%b", starts, 20'b1000000000_1000000000); end
        checks++;
        if (early_under !== 1'b0)
            begin failures++; $display("FAIL b2b_early_underrun got=%b exp=0", early_under); end
    endtask

    task automatic test_hold_buffer();
        int stage = 0;
        int low_run = 0;
        logic low_done = 1'b0;
        symbol_in    = 10'($urandom);
        symbol_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            clock_cycle();
            if (m_acc) stage++;
            checks++;
            if (obs !== m_exp)
                begin failures++; $display("FAIL hold_model cyc=%0d got=%b exp=%b", cyc, obs, m_exp); end
            if (!low_done) begin
                if (!symbol_ready) low_run++;
                else if (low_run > 0) low_done = 1'b1;
            end
            // bit 3 of the first symbol is on the line at i==3
            if (i == 0) symbol_valid = 1'b0;
            if (i == 3) begin symbol_in = 10'($urandom); symbol_valid = 1'b1; end
            if ((i > 3) && m_acc && (stage == 2)) symbol_in = 10'($urandom);
            if (stage >= 3) symbol_valid = 1'b0;
        end
        checks++;
        if (low_run != 6)
            begin failures++; $display("FAIL hold_ready_low_cycles got=%0d exp=6", low_run); end
    endtask

    task automatic test_tx_en_gating();
        int stage = 0;
        logic saw_under = 1'b0;
        symbol_in    = 10'($urandom);
        symbol_valid = 1'b1;
        for (int i = 0; i < 28; i++) begin
            clock_cycle();
            if (m_acc) begin
                stage++;
                if (stage == 1) symbol_in = 10'($urandom);
                else symbol_valid = 1'b0;
            end
            checks++;
            if (obs !== m_exp)
                begin failures++; $display("FAIL txen_model cyc=%0d got=%b exp=%b", cyc, obs, m_exp); end
            if (underrun && (i < 20)) saw_under = 1'b1;
            if ((i >= 10) && (i <= 14)) begin
                checks++;
                if ({serial_valid, symbol_ready} !== 2'b00)
                    begin failures++; $display("FAIL txen_paused i=%0d got=%b exp=00", i, {serial_valid, symbol_ready}); end
            end
            if (i == 15) begin
                checks++;
                if ({serial_valid, symbol_start} !== 2'b11)
                    begin failures++; $display("FAIL txen_resume got=%b exp=11", {serial_valid, symbol_start}); end
            end
            if (i == 5) tx_en = 1'b0;
            if (i == 14) tx_en = 1'b1;
        end
        checks++;
        if (saw_under !== 1'b0)
            begin failures++; $display("FAIL txen_underrun got=%b exp=0", saw_under); end
    endtask

    task automatic test_reset_mid_symbol();
        int stage = 0;
        int leaked = 0;
        symbol_in    = 10'($urandom);
        symbol_valid = 1'b1;
        for (int i = 0; i < 22; i++) begin
            clock_cycle();
            if (m_acc) begin
                stage++;
                if (stage == 1) symbol_in = 10'($urandom);
                else symbol_valid = 1'b0;
            end
            checks++;
            if (obs !== m_exp)
                begin failures++; $display("FAIL rst_mid_model cyc=%0d got=%b exp=%b", cyc, obs, m_exp); end
            if (i == 5) begin
                checks++;
                if (obs !== 5'b00001)
                    begin failures++; $display("FAIL rst_mid_outputs got=%b exp=%b", obs, 5'b00001); end
            end
            if ((i > 5) && serial_valid) leaked++;
            reset = (i == 4);
        end
        checks++;
        if (leaked != 0)
            begin failures++; $display("FAIL rst_mid_leak got=%0d exp=0", leaked); end
    endtask

    task automatic test_random();
        symbol_valid = 1'b0;
        for (int i = 0; i < 600; i++) begin
            clock_cycle();
            checks++;
            if (obs !== m_exp)
                begin failures++; $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, obs, m_exp); end
            // keep an offered symbol stable until it is taken
            if (m_acc || !symbol_valid) begin
                symbol_valid = ($urandom_range(0, 2) != 0) && (i < 560);
                symbol_in    = 10'($urandom);
            end
            tx_en = ($urandom_range(0, 9) != 0) || (i >= 560);
        end
        checks++;
        if ((m_line.size() != 0) || (m_hold.size() != 0) || (serial_valid !== 1'b0))
            begin failures++; $display("FAIL random_drain got_valid=%b exp=0", serial_valid); end
    endtask

    task automatic test_lsb_first();
        logic [SW-1:0] got = '0;
        l_symbol_in    = 10'h274;
        l_symbol_valid = 1'b1;
        l_tx_en        = 1'b1;
        for (int i = 0; i < 11; i++) begin
            clock_cycle();
            l_symbol_valid = 1'b0;
            if (i < SW) begin
                got[SW-1-i] = l_serial_out;
                checks++;
                if ({l_serial_valid, l_symbol_start} !== {1'b1, (i == 0)})
                    begin failures++; $display("FAIL lsb_flags bit=%0d got=%b exp=%b", i,
                        {l_serial_valid, l_symbol_start}, {1'b1, (i == 0)}); end
            end else begin
                checks++;
                if ({l_serial_valid, l_underrun} !== 2'b01)
                    begin failures++; $display("FAIL lsb_underrun got=%b exp=01", {l_serial_valid, l_underrun}); end
            end
        end
        checks++;
        if (got !== 10'b0010111001)
            begin failures++; $display("FAIL lsb_bits got=%b exp=%b", got, 10'b0010111001); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_bypass();
        test_back_to_back();
        test_hold_buffer();
        idle_inputs();
        for (int i = 0; i < 3; i++) clock_cycle();
        test_tx_en_gating();
        idle_inputs();
        for (int i = 0; i < 3; i++) clock_cycle();
        test_reset_mid_symbol();
        idle_inputs();
        test_random();
        idle_inputs();
        for (int i = 0; i < 3; i++) clock_cycle();
        test_lsb_first();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
